// File: rtl/note_pkg.sv
// ----------------------------------------------------------------------------
// note_pkg
// Shared constants, types and helpers for the note player voice.
//   - Field widths for note codes, durations, phase accumulator and samples
//   - Well-known note codes and the codec sample rate
//   - Voice state encoding
//   - Conversion from an accumulator phase to a signed sawtooth sample
// ----------------------------------------------------------------------------
package note_pkg;

    localparam int NOTE_WIDTH     = 6;
    localparam int DURATION_WIDTH = 6;
    localparam int PHASE_WIDTH    = 22;
    localparam int SAMPLE_WIDTH   = 16;

    localparam logic [NOTE_WIDTH-1:0] NOTE_REST = 6'd0;
    localparam logic [NOTE_WIDTH-1:0] NOTE_A4   = 6'd49;
    localparam int                    SAMPLE_RATE = 48000;

    typedef enum logic {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } state_t;

    // The sawtooth is the top bits of the phase accumulator. Inverting the
    // MSB turns an unsigned ramp 0..FFFF into a signed ramp -32768..32767.
    function automatic logic [SAMPLE_WIDTH-1:0] phaseToSample(
        input logic [PHASE_WIDTH-1:0] phase
    );
        logic [SAMPLE_WIDTH-1:0] top;
        top = phase[PHASE_WIDTH-1 -: SAMPLE_WIDTH];
        return top ^ {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    endfunction

endpackage

// File: rtl/note_step_rom.sv
// ----------------------------------------------------------------------------
// note_step_rom
// Combinational lookup from a note code to the phase increment added to the
// accumulator on every 48 kHz sample strobe.
//   step = round(440 * 2^((n-49)/12) * 2^22 / 48000), code 0 (rest) = 0
// Ports:
//   i_note  in   NOTE_WIDTH   note code
//   o_step  out  PHASE_WIDTH  phase increment per sample
// ----------------------------------------------------------------------------
module note_step_rom
    import note_pkg::*;
(
    input  logic [NOTE_WIDTH-1:0]  i_note,
    output logic [PHASE_WIDTH-1:0] o_step
);

    // One equal-tempered semitone per code; code 49 lands on A4 = 440 Hz and
    // every 12 codes doubles the step (one octave up).
    always_comb begin
        o_step = '0;
        case (i_note)
            6'd1:  o_step = 22'd2403;
            6'd2:  o_step = 22'd2546;
            6'd3:  o_step = 22'd2697;
            6'd4:  o_step = 22'd2858;
            6'd5:  o_step = 22'd3028;
            6'd6:  o_step = 22'd3208;
            6'd7:  o_step = 22'd3398;
            6'd8:  o_step = 22'd3600;
            6'd9:  o_step = 22'd3815;
            6'd10: o_step = 22'd4041;
            6'd11: o_step = 22'd4282;
            6'd12: o_step = 22'd4536;
            6'd13: o_step = 22'd4806;
            6'd14: o_step = 22'd5092;
            6'd15: o_step = 22'd5395;
            6'd16: o_step = 22'd5715;
            6'd17: o_step = 22'd6055;
            6'd18: o_step = 22'd6415;
            6'd19: o_step = 22'd6797;
            6'd20: o_step = 22'd7201;
            6'd21: o_step = 22'd7629;
            6'd22: o_step = 22'd8083;
            6'd23: o_step = 22'd8563;
            6'd24: o_step = 22'd9072;
            6'd25: o_step = 22'd9612;
            6'd26: o_step = 22'd10184;
            6'd27: o_step = 22'd10789;
            6'd28: o_step = 22'd11431;
            6'd29: o_step = 22'd12110;
            6'd30: o_step = 22'd12830;
            6'd31: o_step = 22'd13593;
            6'd32: o_step = 22'd14402;
            6'd33: o_step = 22'd15258;
            6'd34: o_step = 22'd16165;
            6'd35: o_step = 22'd17127;
            6'd36: o_step = 22'd18145;
            6'd37: o_step = 22'd19224;
            6'd38: o_step = 22'd20367;
            6'd39: o_step = 22'd21578;
            6'd40: o_step = 22'd22861;
            6'd41: o_step = 22'd24221;
            6'd42: o_step = 22'd25661;
            6'd43: o_step = 22'd27187;
            6'd44: o_step = 22'd28803;
            6'd45: o_step = 22'd30516;
            6'd46: o_step = 22'd32331;
            6'd47: o_step = 22'd34253;
            6'd48: o_step = 22'd36290;
            6'd49: o_step = 22'd38448;
            6'd50: o_step = 22'd40734;
            6'd51: o_step = 22'd43156;
            6'd52: o_step = 22'd45722;
            6'd53: o_step = 22'd48441;
            6'd54: o_step = 22'd51322;
            6'd55: o_step = 22'd54373;
            6'd56: o_step = 22'd57607;
            6'd57: o_step = 22'd61032;
            6'd58: o_step = 22'd64661;
            6'd59: o_step = 22'd68506;
            6'd60: o_step = 22'd72580;
            6'd61: o_step = 22'd76896;
            6'd62: o_step = 22'd81468;
            6'd63: o_step = 22'd86312;
            default: o_step = '0;
        endcase
    end

endmodule

// File: rtl/note_player.sv
// ----------------------------------------------------------------------------
// note_player
// One voice of the three-voice synth. Latches a note and a duration on a load
// pulse, produces a signed sawtooth sample on every codec strobe and pulses
// done_with_note once the note's beats have been used up.
// Ports:
//   clk                   in   system clock
//   reset                 in   asynchronous active-high reset
//   play_enable           in   1 = run, 0 = freeze (loads still accepted)
//   load_new_note         in   one-cycle pulse capturing note/duration
//   note_to_load          in   note code, 0 = rest
//   duration_to_load      in   length in beats (0 behaves as 1)
//   beat                  in   one-cycle beat tick
//   generate_next_sample  in   one-cycle 48 kHz strobe
//   sample_out            out  registered signed sample
//   new_sample_ready      out  one-cycle pulse, sample_out valid
//   done_with_note        out  one-cycle pulse at end of note
//   busy                  out  high while PLAYING
// ----------------------------------------------------------------------------
module note_player
    import note_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      play_enable,
    input  logic                      load_new_note,
    input  logic [NOTE_WIDTH-1:0]     note_to_load,
    input  logic [DURATION_WIDTH-1:0] duration_to_load,
    input  logic                      beat,
    input  logic                      generate_next_sample,
    output logic [SAMPLE_WIDTH-1:0]   sample_out,
    output logic                      new_sample_ready,
    output logic                      done_with_note,
    output logic                      busy
);

    localparam logic [DURATION_WIDTH-1:0] ONE_BEAT = DURATION_WIDTH'(1);

    state_t                    r_state;
    logic [PHASE_WIDTH-1:0]    r_phase;
    logic [PHASE_WIDTH-1:0]    r_step;
    logic [DURATION_WIDTH-1:0] r_beatsLeft;
    logic [SAMPLE_WIDTH-1:0]   r_sample;
    logic                      r_ready;
    logic                      r_done;
    logic                      r_busy;

    logic [PHASE_WIDTH-1:0]    w_loadStep;
    logic [PHASE_WIDTH-1:0]    w_nextPhase;
    logic                      w_strobe;
    logic                      w_beatTick;

    // Step for the note being offered on the load port; only used on a load.
    note_step_rom u_stepRom (
        .i_note (note_to_load),
        .o_step (w_loadStep)
    );

    // Phase wraps naturally at 2^PHASE_WIDTH, which is what makes the ramp
    // a periodic sawtooth.
    assign w_nextPhase = r_phase + r_step;
    assign w_strobe    = play_enable & generate_next_sample;
    assign w_beatTick  = play_enable & beat;

    // Single state machine for the voice. The sample path is evaluated first
    // from the current phase/step, so a load or final beat landing on the same
    // edge as a strobe still produces a sample from the old note; the load
    // branch comes later so its phase clear wins over the phase advance.
    // A load always takes priority over the beat countdown, which is how a
    // restart on the final beat avoids a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_phase     <= '0;
            r_step      <= '0;
            r_beatsLeft <= '0;
            r_sample    <= '0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_done  <= 1'b0;

            if (w_strobe) begin
                r_ready <= 1'b1;
                if (r_state == PLAYING && r_step != '0) begin
                    r_phase  <= w_nextPhase;
                    r_sample <= phaseToSample(w_nextPhase);
                end else begin
                    r_sample <= '0;
                end
            end

            if (load_new_note) begin
                r_state     <= PLAYING;
                r_busy      <= 1'b1;
                r_step      <= w_loadStep;
                r_beatsLeft <= duration_to_load;
                r_phase     <= '0;
            end else if (r_state == PLAYING && w_beatTick) begin
                if (r_beatsLeft <= ONE_BEAT) begin
                    r_done      <= 1'b1;
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_beatsLeft <= '0;
                end else begin
                    r_beatsLeft <= r_beatsLeft - ONE_BEAT;
                end
            end
        end
    end

    assign sample_out       = r_sample;
    assign new_sample_ready = r_ready;
    assign done_with_note   = r_done;
    assign busy             = r_busy;

endmodule

// File: tb/tb_note_player.sv
// ----------------------------------------------------------------------------
// tb_note_player
// Self-checking bench for note_player: a table of one-cycle vectors walked in
// order from reset, then hand-written sequences for beat timing and an
// asynchronous reset in the middle of a note.
// ----------------------------------------------------------------------------
module tb_note_player;

    logic        clk;
    logic        reset;
    logic        play_enable;
    logic        load_new_note;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic        beat;
    logic        generate_next_sample;
    logic [15:0] sample_out;
    logic        new_sample_ready;
    logic        done_with_note;
    logic        busy;

    int compared;
    int mismatched;

    typedef struct {
        logic        load;
        logic [5:0]  note;
        logic [5:0]  dur;
        logic        beat;
        logic        gen;
        logic        en;
        logic [15:0] expSample;
        logic        expReady;
        logic        expDone;
        logic        expBusy;
    } vec_t;

    vec_t vecs[$];

    note_player dut (
        .clk                  (clk),
        .reset                (reset),
        .play_enable          (play_enable),
        .load_new_note        (load_new_note),
        .note_to_load         (note_to_load),
        .duration_to_load     (duration_to_load),
        .beat                 (beat),
        .generate_next_sample (generate_next_sample),
        .sample_out           (sample_out),
        .new_sample_ready     (new_sample_ready),
        .done_with_note       (done_with_note),
        .busy                 (busy)
    );

    // 100 MHz-style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addVec(
        input logic load, input logic [5:0] note, input logic [5:0] dur,
        input logic bt, input logic gen, input logic en,
        input logic [15:0] s, input logic r, input logic d, input logic b
    );
        vec_t v;
        v.load = load; v.note = note; v.dur = dur; v.beat = bt; v.gen = gen;
        v.en = en; v.expSample = s; v.expReady = r; v.expDone = d; v.expBusy = b;
        vecs.push_back(v);
    endfunction

    task automatic checkVal(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Check all four outputs against expected values.
    task automatic checkOutput(input string name, input logic [15:0] s,
                               input logic r, input logic d, input logic b);
        checkVal({name, ".sample"}, int'(sample_out), int'(s));
        checkVal({name, ".ready"},  int'(new_sample_ready), int'(r));
        checkVal({name, ".done"},   int'(done_with_note), int'(d));
        checkVal({name, ".busy"},   int'(busy), int'(b));
    endtask

    // Drive one cycle of inputs (we sit 1 time unit after a rising edge),
    // let the edge take them, then return pulses to 0 and sit #1 past the edge.
    task automatic applyStimulus(input logic load, input logic [5:0] note,
                                 input logic [5:0] dur, input logic bt,
                                 input logic gen, input logic en);
        load_new_note        = load;
        note_to_load         = note;
        duration_to_load     = dur;
        beat                 = bt;
        generate_next_sample = gen;
        play_enable          = en;
        @(posedge clk);
        #1;
        load_new_note        = 1'b0;
        beat                 = 1'b0;
        generate_next_sample = 1'b0;
        play_enable          = 1'b1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int doneCount;
        int doneCyc;
        int busyFallCyc;

        compared             = 0;
        mismatched           = 0;
        play_enable          = 1'b1;
        load_new_note        = 1'b0;
        note_to_load         = '0;
        duration_to_load     = '0;
        beat                 = 1'b0;
        generate_next_sample = 1'b0;

        // Step values: note 49 -> 38448, note 37 -> 19224, note 61 -> 76896.
        // Sample = (phase >> 6) ^ 0x8000.
        //     load  note   dur  beat gen  en   sample    rdy  done busy
        addVec(1'b0, 6'd0,  6'd0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0); // idle strobe
        addVec(1'b0, 6'd0,  6'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0); // ready is a pulse
        addVec(1'b1, 6'd49, 6'd4, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1); // load A4 x4
        addVec(1'b0, 6'd0,  6'd0, 1'b0, 1'b1, 1'b1, 16'h8258, 1'b1, 1'b0, 1'b1); // 38448>>6=600
        addVec(1'b0, 6'd0,  6'd0, 1'b0, 1'b1, 1'b1, 16'h84B1, 1'b1, 1'b0, 1'b1); // 76896>>6=1201
        addVec(1'b0, 6'd0,  6'd0, 1'b0, 1'b1, 1'b1, 16'h870A, 1'b1, 1'b0, 1'b1); // 115344>>6=1802
        addVec(1'b0, 6'd0,  6'd0, 1'b1, 1'b0, 1'b1, 16'h870A, 1'b0, 1'b0, 1'b1); // beats 4->3
        addVec(1'b0, 6'd0,  6'd0, 1'b1, 1'b1, 1'b0, 16'h870A, 1'b0, 1'b0, 1'b1); // paused
        addVec(1'b0, 6'd0,  6'd0, 1'b1, 1'b0, 1'b0, 16'h870A, 1'b0, 1'b0, 1'b1); // paused
        addVec(1'b0, 6'd0,  6'd0, 1'b1, 1'b0, 1'b1, 16'h870A, 1'b0, 1'b0, 1'b1); // beats 3->2
        addVec(1'b0, 6'd0,  6'd0, 1'b1, 1'b1, 1'b1, 16'h8963, 1'b1, 1'b0, 1'b1); // 153792>>6=2403, beats 1
        addVec(1'b0, 6'd0,  6'd0, 1'b1, 1'b1, 1'b1, 16'h8BBB, 1'b1, 1'b1, 1'b0); // final beat+strobe, 192240>>6=3003
        addVec(1'b0, 6'd0,  6'd0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0); // idle after note
        addVec(1'b1, 6'd0,  6'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1); // load rest, dur 0
        addVec(1'b0, 6'd0,  6'd0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1); // rest sample
        addVec(1'b0, 6'd0,  6'd0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0); // dur 0 ends on first beat
        addVec(1'b0, 6'd0,  6'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0); // done is one cycle
        addVec(1'b1, 6'd37, 6'd2, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); // load while paused
        addVec(1'b0, 6'd0,  6'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); // strobe ignored
        addVec(1'b0, 6'd0,  6'd0, 1'b0, 1'b1, 1'b1, 16'h812C, 1'b1, 1'b0, 1'b1); // 19224>>6=300
        addVec(1'b1, 6'd61, 6'd2, 1'b0, 1'b1, 1'b1, 16'h8258, 1'b1, 1'b0, 1'b1); // load+strobe: old note, 38448
        addVec(1'b0, 6'd0,  6'd0, 1'b0, 1'b1, 1'b1, 16'h84B1, 1'b1, 1'b0, 1'b1); // new note from phase 0
        addVec(1'b0, 6'd0,  6'd0, 1'b1, 1'b0, 1'b1, 16'h84B1, 1'b0, 1'b0, 1'b1); // beats 2->1
        addVec(1'b1, 6'd61, 6'd2, 1'b1, 1'b0, 1'b1, 16'h84B1, 1'b0, 1'b0, 1'b1); // final beat + restart
        addVec(1'b0, 6'd0,  6'd0, 1'b0, 1'b1, 1'b1, 16'h84B1, 1'b1, 1'b0, 1'b1); // restarted from phase 0
        addVec(1'b0, 6'd0,  6'd0, 1'b1, 1'b0, 1'b1, 16'h84B1, 1'b0, 1'b0, 1'b1); // beats 2->1
        addVec(1'b0, 6'd0,  6'd0, 1'b1, 1'b0, 1'b1, 16'h84B1, 1'b0, 1'b1, 1'b0); // done after 2 beats
        addVec(1'b0, 6'd0,  6'd0, 1'b0, 1'b0, 1'b1, 16'h84B1, 1'b0, 1'b0, 1'b0); // sample holds in idle

        doReset();
        checkOutput("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].load, vecs[i].note, vecs[i].dur,
                          vecs[i].beat, vecs[i].gen, vecs[i].en);
            checkOutput($sformatf("vec%0d", i), vecs[i].expSample,
                        vecs[i].expReady, vecs[i].expDone, vecs[i].expBusy);
        end

        // Beats at cycles 10, 20, 30 after loading a 3-beat note: exactly one
        // done pulse, visible right after the cycle-30 edge, with busy falling
        // on that same edge.
        doReset();
        applyStimulus(1'b1, 6'd49, 6'd3, 1'b0, 1'b0, 1'b1);
        doneCount   = 0;
        doneCyc     = -1;
        busyFallCyc = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            applyStimulus(1'b0, 6'd0, 6'd0,
                          (cyc == 10 || cyc == 20 || cyc == 30), 1'b0, 1'b1);
            if (done_with_note) begin
                doneCount++;
                doneCyc = cyc;
            end
            if (!busy && busyFallCyc < 0) busyFallCyc = cyc;
        end
        checkVal("dur.doneCount", doneCount, 1);
        checkVal("dur.doneCycle", doneCyc, 30);
        checkVal("dur.busyFall", busyFallCyc, 30);
        applyStimulus(1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("dur.after", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Reset asserted between edges must clear outputs immediately.
        doReset();
        applyStimulus(1'b1, 6'd49, 6'd5, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("async.pre", 16'h8258, 1'b1, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async.during", 16'h0000, 1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 6'd0, 6'd1, 1'b0, 1'b0, 1'b1);
        checkOutput("async.loadRest", 16'h0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("async.restSample", 16'h0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1);
        checkOutput("async.done", 16'h0000, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
